// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - shared types, digit codes and segment patterns for the display mux
package seg_display_pkg;

    typedef enum logic [1:0] {
        MODE_DEC   = 2'd0,
        MODE_HEX   = 2'd1,
        MODE_BLANK = 2'd2,
        MODE_LAMP  = 2'd3
    } mode_e;

    // Codes 0x00..0x0F are plain nibbles; bit 4 marks the special glyphs.
    typedef logic [4:0] digit_code_t;

    localparam digit_code_t CODE_DASH  = 5'h10;
    localparam digit_code_t CODE_BLANK = 5'h11;

    // Active-low {g,f,e,d,c,b,a}; the decimal point is added by the scanner.
    function automatic logic [6:0] code_to_seg(input digit_code_t code);
        logic [6:0] s;
        case (code)
            5'h00:     s = 7'h40;
            5'h01:     s = 7'h79;
            5'h02:     s = 7'h24;
            5'h03:     s = 7'h30;
            5'h04:     s = 7'h19;
            5'h05:     s = 7'h12;
            5'h06:     s = 7'h02;
            5'h07:     s = 7'h78;
            5'h08:     s = 7'h00;
            5'h09:     s = 7'h10;
            5'h0A:     s = 7'h08;
            5'h0B:     s = 7'h03;
            5'h0C:     s = 7'h46;
            5'h0D:     s = 7'h21;
            5'h0E:     s = 7'h06;
            5'h0F:     s = 7'h0E;
            CODE_DASH: s = 7'h3F;
            default:   s = 7'h7F;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] dec_limit(input int digits);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 32'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble, one add-3/shift step per clock
module bin2bcd_seq #(
    parameter int VALUE_WIDTH = 14,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic [VALUE_WIDTH-1:0]  value_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    state_e                 state_q;
    logic [VALUE_WIDTH-1:0] bin_q;
    logic [BCD_W-1:0]       bcd_q;
    logic [BCD_W-1:0]       bcd_adj;
    logic [CNT_W-1:0]       cnt_q;
    logic                   busy_q;
    logic                   done_q;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Digits beyond NUM_DIGITS fall off the top; only overflowing values lose them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        bin_q   <= value_i;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[VALUE_WIDTH-1]};
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(VALUE_WIDTH - 1)) begin
                        state_q <= S_COMMIT;
                        done_q  <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_display_mux.sv
// rtl/seg_display_mux.sv - multiplexed common-anode 7-segment driver with BCD/hex,
// leading-zero blanking, blink and lamp test
module seg_display_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int VALUE_WIDTH    = 14,
    parameter int REFRESH_CYCLES = 1000,
    parameter int BLINK_FRAMES   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [VALUE_WIDTH-1:0] value_in,
    input  logic                   load,
    input  logic [1:0]             mode,
    input  logic                   lz_blank,
    input  logic                   blink_en,
    input  logic [NUM_DIGITS-1:0]  dp_mask,
    output logic                   busy,
    output logic                   overflow,
    output logic [7:0]             segment_display,
    output logic [NUM_DIGITS-1:0]  digit_select,
    output logic                   frame_tick
);
    import seg_display_pkg::*;

    localparam int          BCD_W     = 4 * NUM_DIGITS;
    localparam int          RC_W      = $clog2(REFRESH_CYCLES);
    localparam int          SEL_W     = $clog2(NUM_DIGITS);
    localparam int          BK_W      = $clog2(BLINK_FRAMES + 1);
    localparam logic [31:0] DEC_LIMIT = dec_limit(NUM_DIGITS);

    mode_e            mode_w;
    logic             accept;
    logic             hex_load;
    logic             conv_start;
    logic             conv_busy;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic [BCD_W-1:0] hex_nibbles;
    logic [BCD_W-1:0] nib_src;
    logic [31:0]      value_ext;
    logic             lz_src;
    logic             lead;
    logic             dash;
    digit_code_t      new_codes [NUM_DIGITS];
    digit_code_t      codes_q   [NUM_DIGITS];
    logic             ovf_q;
    logic             lz_q;

    assign mode_w     = mode_e'(mode);
    assign accept     = load && !conv_busy;
    assign hex_load   = accept && (mode_w == MODE_HEX);
    assign conv_start = accept && (mode_w == MODE_DEC);
    assign value_ext  = 32'(value_in);

    if (VALUE_WIDTH >= BCD_W) begin : g_hex_trunc
        assign hex_nibbles = value_in[BCD_W-1:0];
    end else begin : g_hex_ext
        assign hex_nibbles = {{(BCD_W - VALUE_WIDTH){1'b0}}, value_in};
    end

    bin2bcd_seq #(
        .VALUE_WIDTH(VALUE_WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk    (clk),
        .reset  (reset),
        .start_i(conv_start),
        .value_i(value_in),
        .busy_o (conv_busy),
        .done_o (conv_done),
        .bcd_o  (conv_bcd)
    );

    // Hex loads commit on acceptance; decimal loads commit when the converter finishes.
    always_comb begin
        nib_src   = hex_load ? hex_nibbles : conv_bcd;
        lz_src    = hex_load ? lz_blank : lz_q;
        dash      = !hex_load && ovf_q;
        lead      = lz_src;
        new_codes = '{default: CODE_BLANK};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if ((nib_src[4*i +: 4] != 4'd0) || (i == 0)) begin
                lead = 1'b0;
            end
            if (dash) begin
                new_codes[i] = CODE_DASH;
            end else if (lead) begin
                new_codes[i] = CODE_BLANK;
            end else begin
                new_codes[i] = {1'b0, nib_src[4*i +: 4]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q   <= 1'b0;
            lz_q    <= 1'b0;
            codes_q <= '{default: CODE_BLANK};
        end else if (accept) begin
            lz_q <= lz_blank;
            case (mode_w)
                MODE_DEC: ovf_q <= (value_ext >= DEC_LIMIT);
                MODE_HEX: begin
                    ovf_q   <= 1'b0;
                    codes_q <= new_codes;
                end
                default: ;
            endcase
        end else if (conv_done) begin
            codes_q <= new_codes;
        end
    end

    logic [RC_W-1:0]       refresh_q, refresh_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic                  active_q, active_d;
    logic [BK_W-1:0]       blink_cnt_q, blink_cnt_d;
    logic                  phase_q, phase_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dsel_q, dsel_d;
    logic                  tick_q, tick_d;
    logic [NUM_DIGITS-1:0] onehot_n;
    logic                  term;
    logic                  step;
    logic                  wrap;

    // active_q stays low until the first slot completes, so digit 0 is the first one lit.
    always_comb begin
        term      = (refresh_q == RC_W'(REFRESH_CYCLES - 1));
        refresh_d = term ? '0 : refresh_q + RC_W'(1);
        step      = term && active_q;
        wrap      = step && (sel_q == SEL_W'(NUM_DIGITS - 1));
        active_d  = active_q || term;
        sel_d     = sel_q;
        if (step) begin
            sel_d = wrap ? '0 : sel_q + SEL_W'(1);
        end
        tick_d = wrap;

        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (!blink_en) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (wrap) begin
            if (blink_cnt_q == BK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = !phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BK_W'(1);
            end
        end

        onehot_n = ~(NUM_DIGITS'(1) << sel_d);
        seg_d    = 8'hFF;
        dsel_d   = '1;
        if (active_d) begin
            if (mode_w == MODE_LAMP) begin
                dsel_d = onehot_n;
                seg_d  = 8'h00;
            end else if (!(blink_en && phase_d)) begin
                dsel_d = onehot_n;
                if (mode_w != MODE_BLANK) begin
                    seg_d = {~dp_mask[sel_d], code_to_seg(codes_q[sel_d])};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_q   <= '0;
            sel_q       <= '0;
            active_q    <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            seg_q       <= 8'hFF;
            dsel_q      <= '1;
            tick_q      <= 1'b0;
        end else begin
            refresh_q   <= refresh_d;
            sel_q       <= sel_d;
            active_q    <= active_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            seg_q       <= seg_d;
            dsel_q      <= dsel_d;
            tick_q      <= tick_d;
        end
    end

    assign busy            = conv_busy;
    assign overflow        = ovf_q;
    assign segment_display = seg_q;
    assign digit_select    = dsel_q;
    assign frame_tick      = tick_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// tb/tb_seg_display_mux.sv - self-checking bench for seg_display_mux
module tb_seg_display_mux;
    localparam int N  = 4;
    localparam int VW = 14;
    localparam int R  = 4;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [VW-1:0] value_in = '0;
    logic          load = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          lz_blank = 1'b0;
    logic          blink_en = 1'b0;
    logic [N-1:0]  dp_mask = '0;
    logic          busy;
    logic          overflow;
    logic [7:0]    segment_display;
    logic [N-1:0]  digit_select;
    logic          frame_tick;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] seg_tab [16];

    seg_display_mux #(
        .NUM_DIGITS(N), .VALUE_WIDTH(VW), .REFRESH_CYCLES(R), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .value_in(value_in), .load(load), .mode(mode),
        .lz_blank(lz_blank), .blink_en(blink_en), .dp_mask(dp_mask), .busy(busy),
        .overflow(overflow), .segment_display(segment_display),
        .digit_select(digit_select), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_digit(input int unsigned v, input int m, input bit lz, input int d);
        int unsigned p;
        p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        if (m == 0) begin
            if (v >= 10000) return 8'hBF;
            if (lz && d > 0 && v < p) return 8'hFF;
            return seg_tab[(v / p) % 10];
        end
        if (lz && d > 0 && (v >> (4 * d)) == 0) return 8'hFF;
        return seg_tab[(v >> (4 * d)) & 15];
    endfunction

    task automatic do_load(input int unsigned v, input logic [1:0] m, input bit lz);
        @(negedge clk);
        value_in = VW'(v);
        mode = m;
        lz_blank = lz;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        expect_eq(tag, busy, 1'b0);
    endtask

    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (frame_tick !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        expect_eq({tag, "_sync"}, frame_tick, 1'b1);
    endtask

    task automatic check_frame(input string tag, input int unsigned v, input int m,
                               input bit lz, input logic [N-1:0] dpm);
        logic [7:0]   e;
        logic [N-1:0] ed;
        int           d;
        wait_tick(tag);
        for (int c = 0; c < N * R; c++) begin
            if (c > 0) @(negedge clk);
            d = c / R;
            e = exp_digit(v, m, lz, d);
            e[7] = ~dpm[d];
            ed = ~(4'b0001 << d);
            expect_eq({tag, "_dsel"}, digit_select, ed);
            expect_eq({tag, "_seg"}, segment_display, e);
            expect_eq({tag, "_ftick"}, frame_tick, (c == 0));
        end
        @(negedge clk);
        expect_eq({tag, "_period"}, frame_tick, 1'b1);
    endtask

    task automatic reset_pulse(input string tag);
        int n;
        #2 reset = 1'b1;
        #1;
        expect_eq({tag, "_seg"}, segment_display, 8'hFF);
        expect_eq({tag, "_dsel"}, digit_select, 4'hF);
        expect_eq({tag, "_busy"}, busy, 1'b0);
        expect_eq({tag, "_ovf"}, overflow, 1'b0);
        expect_eq({tag, "_ftick"}, frame_tick, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (digit_select === 4'hF && n < 50);
        expect_eq({tag, "_first_cycle"}, n, R);
        expect_eq({tag, "_first_dsel"}, digit_select, 4'hE);
        expect_eq({tag, "_first_seg"}, segment_display, 8'hFF);
        expect_eq({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n;
        int          ticks;
        int unsigned v;
        int          m;
        bit          lz;
        bit          blanked;
        logic [N-1:0] dpm;
        logic [N-1:0] lit;

        seg_tab[0] = 8'hC0; seg_tab[1] = 8'hF9; seg_tab[2] = 8'hA4; seg_tab[3] = 8'hB0;
        seg_tab[4] = 8'h99; seg_tab[5] = 8'h92; seg_tab[6] = 8'h82; seg_tab[7] = 8'hF8;
        seg_tab[8] = 8'h80; seg_tab[9] = 8'h90; seg_tab[10] = 8'h88; seg_tab[11] = 8'h83;
        seg_tab[12] = 8'hC6; seg_tab[13] = 8'hA1; seg_tab[14] = 8'h86; seg_tab[15] = 8'h8E;

        reset_pulse("rst_init");

        do_load(1234, 2'd0, 1'b0);
        repeat (5) @(negedge clk);
        reset_pulse("rst_mid");

        do_load(1234, 2'd0, 1'b0);
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        expect_eq("busy_len", n, VW + 1);
        expect_eq("ovf_1234", overflow, 1'b0);
        check_frame("dec1234", 1234, 0, 1'b0, '0);

        do_load(7, 2'd0, 1'b1);
        wait_idle("idle_7lz");
        check_frame("dec7_lz", 7, 0, 1'b1, '0);
        do_load(7, 2'd0, 1'b0);
        wait_idle("idle_7");
        check_frame("dec7", 7, 0, 1'b0, '0);

        do_load(12000, 2'd0, 1'b0);
        expect_eq("ovf_set", overflow, 1'b1);
        wait_idle("idle_ovf");
        check_frame("dash", 12000, 0, 1'b0, '0);
        do_load(32'h2AF, 2'd1, 1'b0);
        expect_eq("ovf_clr", overflow, 1'b0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0) n++;
        end
        expect_eq("hex_busy", n, 0);
        check_frame("hex2af", 32'h2AF, 1, 1'b0, '0);

        for (int it = 0; it < 12; it++) begin
            v   = $urandom_range(0, 16383);
            m   = $urandom_range(0, 1);
            lz  = 1'($urandom_range(0, 1));
            dpm = N'($urandom_range(0, 15));
            dp_mask = dpm;
            do_load(v, 2'(m), lz);
            wait_idle("rnd_idle");
            expect_eq("rnd_ovf", overflow, (m == 0 && v >= 10000));
            check_frame("rnd", v, m, lz, dpm);
        end
        dp_mask = '0;

        do_load(99, 2'd0, 1'b0);
        repeat (3) @(negedge clk);
        do_load(55, 2'd0, 1'b0);
        wait_idle("idle_99");
        repeat (3) @(negedge clk);
        expect_eq("no_queue", busy, 1'b0);
        check_frame("dec99", 99, 0, 1'b0, '0);

        mode = 2'd2;
        @(negedge clk);
        for (int c = 0; c < N * R; c++) begin
            @(negedge clk);
            lit = ~digit_select;
            expect_eq("m2_seg", segment_display, 8'hFF);
            expect_eq("m2_dsel", $countones(lit), 1);
        end
        mode = 2'd0;

        wait_tick("blink");
        blink_en = 1'b1;
        ticks = 0;
        for (int c = 0; c < 6 * N * R; c++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ticks++;
            if (c % R == 1) begin
                blanked = ((ticks / BF) % 2) == 1;
                expect_eq("blink_dsel", (digit_select == 4'hF), blanked);
                expect_eq("blink_seg", (segment_display == 8'hFF), blanked);
            end
        end

        mode = 2'd3;
        @(negedge clk);
        for (int c = 0; c < 4 * N * R; c++) begin
            @(negedge clk);
            if (c % R == 2) begin
                lit = ~digit_select;
                expect_eq("lamp_seg", segment_display, 8'h00);
                expect_eq("lamp_dsel", $countones(lit), 1);
            end
        end

        mode = 2'd0;
        blink_en = 1'b0;
        dp_mask = 4'b0010;
        check_frame("dp", 99, 0, 1'b0, 4'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
